// File: rtl/led_pkg.sv
// Shared definitions for the LED frame scanner: geometry defaults, scan state,
// row index type and the row-to-one-hot helper.
package led_pkg;

    localparam int COLS_DEF = 50;
    localparam int ROWS_DEF = 5;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_e;

    typedef logic [2:0] row_idx_t;

    function automatic logic [7:0] row_onehot(input row_idx_t row);
        return 8'd1 << row;
    endfunction

endpackage

// File: rtl/led_row_timer.sv
// Phase timer owned by the scan FSM: counts cycles in the current phase and
// flags the last one; it restarts from zero on the cycle after done.
module led_row_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] last_i,
    output logic             done_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Advance the count, restarting when the programmed length is reached.
    always_comb begin
        done_o = (cnt_q == last_i);
        if (done_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/led_frame_scanner.sv
// Double-buffered ROWS x COLS frame scanner with a blanking gap before every row.
// Defining LED_BRIGHTNESS_EN adds a brightness input that trims the lit part of each dwell.
module led_frame_scanner
    import led_pkg::*;
#(
    parameter int COLS         = COLS_DEF,
    parameter int ROWS         = ROWS_DEF,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int CNT_W        = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [2:0]      wr_row,
    input  logic [COLS-1:0] wr_data,
    input  logic            commit,
    output logic            commit_pending,
    output logic            frame_start,
    output logic [2:0]      row_idx,
    output logic [COLS-1:0] outbus,
    output logic [ROWS-1:0] gnd
`ifdef LED_BRIGHTNESS_EN
    ,
    input  logic [3:0]      brightness
`endif
);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam row_idx_t         ROW_LAST   = row_idx_t'(ROWS - 1);

    scan_state_e     state_q, state_d;
    row_idx_t        row_q, row_d;
    logic            front_sel_q, front_sel_d;
    logic            pending_q, pending_d;
    logic            frame_start_q, frame_start_d;
    logic [COLS-1:0] outbus_q, outbus_d;
    logic [ROWS-1:0] gnd_q, gnd_d;
    logic [COLS-1:0] buf_q [2][ROWS];

    logic [CNT_W-1:0] tmr_last_s;
    logic [CNT_W-1:0] tmr_cnt_s;
    logic [CNT_W-1:0] tmr_next_s;
    logic             tmr_done_s;
    logic             row_end_s;
    logic             boundary_s;
    logic             frame_entry_s;
    logic             wr_fire_s;
    logic             lit_s;
    logic [3:0]       bright_eff_s;
    logic [31:0]      lit_thr_s;

    assign tmr_last_s = (state_q == ON) ? DWELL_LAST : BLANK_LAST;

    led_row_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .last_i (tmr_last_s),
        .done_o (tmr_done_s),
        .cnt_o  (tmr_cnt_s)
    );

    assign row_end_s     = (state_q == ON) && tmr_done_s;
    assign boundary_s    = row_end_s && (row_q == ROW_LAST);
    assign frame_entry_s = (state_q == BLANK) && tmr_done_s && (row_q == 3'd0);
    assign wr_fire_s     = wr_valid && !pending_q;

`ifdef LED_BRIGHTNESS_EN
    logic [3:0] bright_q;

    // The level seen on frame entry applies to every row of that frame.
    assign bright_eff_s = frame_entry_s ? brightness : bright_q;

    // Brightness capture register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bright_q <= 4'hF;
        end else if (frame_entry_s) begin
            bright_q <= brightness;
        end else begin
            bright_q <= bright_q;
        end
    end
`else
    assign bright_eff_s = 4'hF;
`endif

    // Scan state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // Next scan state: each phase ends on the timer's last cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BLANK:   state_d = tmr_done_s ? ON : BLANK;
            ON:      state_d = tmr_done_s ? BLANK : ON;
            default: state_d = BLANK;
        endcase
    end

    // Next registered outputs, computed from the next state so they move together.
    always_comb begin
        outbus_d      = '0;
        gnd_d         = '0;
        frame_start_d = 1'b0;
        tmr_next_s    = tmr_done_s ? '0 : tmr_cnt_s + CNT_W'(1);
        lit_thr_s     = (32'(DWELL_CYCLES) * (32'(bright_eff_s) + 32'd1)) >> 4'd4;
        lit_s         = (32'(tmr_next_s) < lit_thr_s);
        if (state_d == ON) begin
            gnd_d         = ROWS'(row_onehot(row_q));
            frame_start_d = frame_entry_s;
            if (lit_s) begin
                outbus_d = buf_q[front_sel_q][row_q];
            end else begin
                outbus_d = '0;
            end
        end else begin
            outbus_d      = '0;
            gnd_d         = '0;
            frame_start_d = 1'b0;
        end
    end

    // Row advance, commit arming and buffer swap at the frame boundary.
    always_comb begin
        row_d       = row_q;
        front_sel_d = front_sel_q;
        pending_d   = pending_q;
        if (row_end_s) begin
            row_d = (row_q == ROW_LAST) ? 3'd0 : row_q + 3'd1;
        end else begin
            row_d = row_q;
        end
        // A pending swap takes the boundary; a commit landing there waits a frame.
        if (boundary_s && pending_q) begin
            front_sel_d = ~front_sel_q;
            pending_d   = 1'b0;
        end else if (commit && !pending_q) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q         <= 3'd0;
            front_sel_q   <= 1'b0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
            outbus_q      <= '0;
            gnd_q         <= '0;
        end else begin
            row_q         <= row_d;
            front_sel_q   <= front_sel_d;
            pending_q     <= pending_d;
            frame_start_q <= frame_start_d;
            outbus_q      <= outbus_d;
            gnd_q         <= gnd_d;
        end
    end

    // Back-buffer writes; out-of-range rows complete the handshake but are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    buf_q[b][r] <= '0;
                end
            end
        end else if (wr_fire_s && (wr_row <= ROW_LAST)) begin
            buf_q[~front_sel_q][wr_row] <= wr_data;
        end
    end

    assign wr_ready       = !pending_q;
    assign commit_pending = pending_q;
    assign frame_start    = frame_start_q;
    assign row_idx        = row_q;
    assign outbus         = outbus_q;
    assign gnd            = gnd_q;

endmodule

// File: tb/tb_led_frame_scanner.sv
// Randomized bench for led_frame_scanner against a schedule-based frame model.
module tb_led_frame_scanner;

    localparam int COLS  = 50;
    localparam int ROWS  = 5;
    localparam int DWELL = 8;
    localparam int BLANK = 2;
    localparam int PER   = BLANK + DWELL;
    localparam int FP    = ROWS * PER;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wr_valid;
    logic            wr_ready;
    logic [2:0]      wr_row;
    logic [COLS-1:0] wr_data;
    logic            commit;
    logic            commit_pending;
    logic            frame_start;
    logic [2:0]      row_idx;
    logic [COLS-1:0] outbus;
    logic [ROWS-1:0] gnd;
`ifdef LED_BRIGHTNESS_EN
    logic [3:0]      brightness;
`endif

    always #5 clk = ~clk;

    led_frame_scanner #(
        .COLS         (COLS),
        .ROWS         (ROWS),
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (BLANK),
        .CNT_W        (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_row         (wr_row),
        .wr_data        (wr_data),
        .commit         (commit),
        .commit_pending (commit_pending),
        .frame_start    (frame_start),
        .row_idx        (row_idx),
        .outbus         (outbus),
        .gnd            (gnd)
`ifdef LED_BRIGHTNESS_EN
        ,
        .brightness     (brightness)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: displayed/back frames, pending flag, cycles since reset release.
    logic [COLS-1:0] m_front [ROWS];
    logic [COLS-1:0] m_back  [ROWS];
    bit              m_pending;
    int              t;
    int              m_bright;
    bit              did_rst;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++) begin
            m_front[r] = '0;
            m_back[r]  = '0;
        end
        m_pending = 1'b0;
        t         = 0;
        m_bright  = 15;
    endtask

    // Apply what the DUT saw at the clock edge that just happened.
    task automatic model_edge();
        logic [COLS-1:0] tmp;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (wr_valid && !m_pending && (wr_row < ROWS)) m_back[wr_row] = wr_data;
        if ((((t + 1) % FP) == 0) && m_pending) begin
            for (int r = 0; r < ROWS; r++) begin
                tmp        = m_front[r];
                m_front[r] = m_back[r];
                m_back[r]  = tmp;
            end
            m_pending = 1'b0;
        end else if (commit && !m_pending) begin
            m_pending = 1'b1;
        end
        t++;
`ifdef LED_BRIGHTNESS_EN
        if ((t % FP) == BLANK) m_bright = int'(brightness);
`endif
    endtask

    task automatic check_outputs();
        int              pos;
        int              row;
        int              off;
        bit              lit;
        logic [COLS-1:0] exp_bus;
        logic [ROWS-1:0] exp_gnd;
        pos     = t % FP;
        row     = pos / PER;
        off     = pos % PER;
        lit     = (off >= BLANK);
        exp_gnd = lit ? (ROWS'(1) << row) : '0;
        exp_bus = lit ? m_front[row] : '0;
        if (lit && ((off - BLANK) >= (DWELL * (m_bright + 1)) / 16)) exp_bus = '0;
        check_value("outbus", outbus, exp_bus);
        check_value("gnd", gnd, exp_gnd);
        check_value("row_idx", row_idx, row);
        check_value("frame_start", frame_start, lit && (row == 0) && (off == BLANK));
        check_value("commit_pending", commit_pending, m_pending);
        check_value("wr_ready", wr_ready, !m_pending);
    endtask

    task automatic drive_inputs(input int cyc);
        int pos;
        pos      = t % FP;
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        commit   = 1'b0;
        wr_row   = 3'($urandom_range(0, 7));
        wr_data  = COLS'({$urandom, $urandom});
`ifdef LED_BRIGHTNESS_EN
        if ($urandom_range(0, 7) == 0) brightness = 4'($urandom_range(0, 15));
`endif
        if (cyc == 0) begin
            wr_valid = 1'b1;
            wr_row   = 3'd2;
            wr_data  = 50'h3_FFFF_FFFF_FFFF;
        end else if (cyc == 1) begin
            commit = 1'b1;
        end else if (cyc < 160) begin
            wr_valid = 1'b0;
        end else if (cyc == 160) begin
            wr_valid = 1'b1;
            wr_row   = 3'd7;
            wr_data  = '1;
        end else if (cyc == 161) begin
            commit = 1'b1;
        end else if (cyc < 700) begin
            wr_valid = ($urandom_range(0, 1) == 1);
            commit   = ($urandom_range(0, 15) == 0);
        end else if (cyc < 1000) begin
            wr_valid = ($urandom_range(0, 1) == 1);
            commit   = (((t + 1) % FP) == 0);
        end else if (!did_rst) begin
            commit = 1'b1;
            if (((pos / PER) == 3) && ((pos % PER) >= BLANK) && m_pending) begin
                rst_n   = 1'b0;
                did_rst = 1'b1;
            end
        end else begin
            wr_valid = ($urandom_range(0, 1) == 1);
            commit   = ($urandom_range(0, 11) == 0);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_row   = 3'd0;
        wr_data  = '0;
        commit   = 1'b0;
        did_rst  = 1'b0;
`ifdef LED_BRIGHTNESS_EN
        brightness = 4'd3;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 1400; cyc++) begin
            check_outputs();
            drive_inputs(cyc);
            @(posedge clk);
            model_edge();
            #1;
        end
        check_value("mid_reset_seen", did_rst, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
